// File: rtl/cnn_pkg.sv
// Shared constants, FSM state and step encoding for the CNN layer controller.
// Word counts are also used by the datapath and the testbench.
package cnn_pkg;

  localparam int DATA_W    = 32;
  localparam int IMG_WORDS = 75;
  localparam int CH_WORDS  = 25;
  localparam int KER_WORDS = 12;
  localparam int W_WORDS   = 24;
  localparam int N_OUT     = 3;
  localparam int N_CONV    = 3;
  localparam int N_STEPS   = 6;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  localparam logic [2:0] STEP_CONV0   = 3'd0;
  localparam logic [2:0] STEP_CONV1   = 3'd1;
  localparam logic [2:0] STEP_CONV2   = 3'd2;
  localparam logic [2:0] STEP_ACT     = 3'd3;
  localparam logic [2:0] STEP_FC      = 3'd4;
  localparam logic [2:0] STEP_SOFTMAX = 3'd5;

  // Words that must have been loaded before a step may start: a conv channel
  // needs its own channel in the buffer, later steps need the whole image.
  function automatic logic [6:0] step_threshold(input logic [2:0] id);
    if (id < 3'(N_CONV)) return 7'(CH_WORDS * (int'(id) + 1));
    else                 return 7'(IMG_WORDS);
  endfunction

endpackage

// File: rtl/cnn_load_addr.sv
// Load-word counter and buffer write-enable/address decode for the input stream.
module cnn_load_addr
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_accept,
  input  logic       i_hold,
  output logic [6:0] o_cnt,
  output logic       o_last,
  output logic       o_img_we,
  output logic [6:0] o_img_addr,
  output logic       o_ker_we,
  output logic [3:0] o_ker_addr,
  output logic       o_w_we,
  output logic [4:0] o_w_addr
);

  logic [6:0] r_cnt;
  logic       w_ker;
  logic       w_w;

  // The count survives CALC so the scheduler can still see a complete load;
  // any other non-accepting cycle (idle, abort, output) rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (i_accept) r_cnt <= r_cnt + 7'd1;
    else if (!i_hold)  r_cnt <= '0;
  end

  assign w_ker = i_accept && (r_cnt < 7'(KER_WORDS));
  assign w_w   = i_accept && (r_cnt < 7'(W_WORDS));

  assign o_cnt      = r_cnt;
  assign o_last     = i_accept && (r_cnt == 7'(IMG_WORDS - 1));
  assign o_img_we   = i_accept;
  assign o_img_addr = i_accept ? r_cnt : '0;
  assign o_ker_we   = w_ker;
  assign o_ker_addr = w_ker ? r_cnt[3:0] : '0;
  assign o_w_we     = w_w;
  assign o_w_addr   = w_w ? r_cnt[4:0] : '0;

endmodule

// File: rtl/cnn_sched.sv
// CNN layer controller: loads the input stream, issues the six datapath steps
// one at a time, then bursts the softmax results out.
module cnn_sched
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    opt_in,
  output logic                    img_we,
  output logic [6:0]              img_addr,
  output logic                    ker_we,
  output logic [3:0]              ker_addr,
  output logic                    w_we,
  output logic [4:0]              w_addr,
  output logic                    opt_q,
  output logic                    step_valid,
  output logic [2:0]              step_id,
  input  logic                    step_done,
  input  logic [N_OUT*DATA_W-1:0] res,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out
);

  state_t            r_state, w_next;
  logic [6:0]        w_cnt;
  logic              w_accept, w_last;
  logic [2:0]        r_next_id, r_step_id;
  logic              r_busy, r_step_valid, r_opt;
  logic              w_done, w_issue;
  logic [1:0]        r_ocnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out;

  assign w_accept = in_valid && (r_state == IDLE || r_state == LOAD);

  cnn_load_addr u_load_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_accept   (w_accept),
    .i_hold     (r_state == CALC),
    .o_cnt      (w_cnt),
    .o_last     (w_last),
    .o_img_we   (img_we),
    .o_img_addr (img_addr),
    .o_ker_we   (ker_we),
    .o_ker_addr (ker_addr),
    .o_w_we     (w_we),
    .o_w_addr   (w_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  assign w_done = r_busy && step_done;

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = LOAD;
      LOAD: begin
        if (!in_valid)   w_next = IDLE;
        else if (w_last) w_next = CALC;
      end
      CALC: if (w_done && r_next_id == STEP_SOFTMAX) w_next = OUT;
      OUT:  if (r_ocnt == 2'(N_OUT)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Gating on w_next keeps a step from issuing on the edge a load aborts.
  assign w_issue = !r_busy && (r_next_id < 3'(N_STEPS))
                && (w_cnt >= step_threshold(r_next_id))
                && (w_next == LOAD || w_next == CALC)
                && (r_state == LOAD || r_state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_next_id    <= STEP_CONV0;
      r_step_id    <= STEP_CONV0;
      r_step_valid <= 1'b0;
    end else if (r_state == IDLE || r_state == OUT) begin
      r_busy       <= 1'b0;
      r_next_id    <= STEP_CONV0;
      r_step_valid <= 1'b0;
    end else begin
      r_step_valid <= w_issue;
      if (w_issue) begin
        r_busy    <= 1'b1;
        r_step_id <= r_next_id;
      end else if (w_done) begin
        r_busy    <= 1'b0;
        r_next_id <= r_next_id + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_opt <= 1'b0;
    else if (r_state == IDLE && in_valid) r_opt <= opt_in;
  end

  // OUT spends N_OUT edges capturing result words and one more edge clearing
  // out_valid, so the burst has ended by the time the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ocnt      <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (r_state == OUT && r_ocnt < 2'(N_OUT)) begin
      r_ocnt      <= r_ocnt + 2'd1;
      r_out_valid <= 1'b1;
      r_out       <= res[DATA_W*int'(r_ocnt) +: DATA_W];
    end else begin
      r_ocnt      <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end
  end

  assign opt_q      = r_opt;
  assign step_valid = r_step_valid;
  assign step_id    = r_step_id;
  assign out_valid  = r_out_valid;
  assign out        = r_out;

endmodule

// File: tb/tb_cnn_sched.sv
// Scoreboard bench for cnn_sched: directed patterns, a latency-programmable
// datapath model, and a monitor comparing issued steps and output words.
module tb_cnn_sched;
  import cnn_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid, opt_in, step_done;
  logic                    img_we, ker_we, w_we, opt_q, step_valid, out_valid;
  logic [6:0]              img_addr;
  logic [3:0]              ker_addr;
  logic [4:0]              w_addr;
  logic [2:0]              step_id;
  logic [N_OUT*DATA_W-1:0] res;
  logic [DATA_W-1:0]       out;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int dp_lat = 3;
  int load_start = 0;
  int step0_cyc = -1;
  bit outstanding = 1'b0;
  logic [2:0]        step_q[$];
  logic [DATA_W-1:0] out_q[$];

  cnn_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opt_in(opt_in),
    .img_we(img_we), .img_addr(img_addr), .ker_we(ker_we), .ker_addr(ker_addr),
    .w_we(w_we), .w_addr(w_addr), .opt_q(opt_q), .step_valid(step_valid),
    .step_id(step_id), .step_done(step_done), .res(res),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath model: answers each issued step dp_lat cycles later.
  initial begin
    step_done = 1'b0;
    forever begin
      @(negedge clk);
      if (step_valid) begin
        repeat (dp_lat) @(posedge clk);
        #1 step_done = 1'b1;
        @(posedge clk);
        #1 step_done = 1'b0;
      end
    end
  end

  // Monitor: pops expected steps/words whenever the DUT presents one.
  initial forever begin
    logic [2:0]        es;
    logic [DATA_W-1:0] ew;
    @(negedge clk);
    if (step_valid) begin
      check("step_overlap", 32'(outstanding), 32'd0);
      outstanding = 1'b1;
      if (step_q.size() > 0) begin
        es = step_q.pop_front();
        check("step_id", 32'(step_id), 32'(es));
        if (es == STEP_CONV0) step0_cyc = cyc;
      end else check("step_extra", 32'(step_valid), 32'd0);
    end else if (step_done) outstanding = 1'b0;
    if (out_valid) begin
      check("out_in_overlap", 32'(in_valid), 32'd0);
      if (out_q.size() > 0) begin
        ew = out_q.pop_front();
        check("out_word", out, ew);
      end else check("out_extra", 32'(out_valid), 32'd0);
    end else check("out_zero", out, 32'd0);
  end

  task automatic drive_load(input int n, input bit opt);
    @(posedge clk);
    #1 load_start = cyc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      opt_in   = (i == 0) ? opt : ~opt;
      @(negedge clk);
      check("img_we",   32'(img_we),   32'd1);
      check("img_addr", 32'(img_addr), 32'(i));
      check("ker_we",   32'(ker_we),   32'(i < KER_WORDS));
      check("ker_addr", 32'(ker_addr), (i < KER_WORDS) ? 32'(i) : 32'd0);
      check("w_we",     32'(w_we),     32'(i < W_WORDS));
      check("w_addr",   32'(w_addr),   (i < W_WORDS) ? 32'(i) : 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    opt_in   = 1'b0;
  endtask

  task automatic run_pattern(input bit opt, input int lat, input int nwords,
                             input bit calc_pulse, input bit rst_out,
                             input logic [31:0] base);
    int k;
    dp_lat    = lat;
    step0_cyc = -1;
    res = {base + 32'd2, base + 32'd1, base};
    if (nwords == IMG_WORDS) begin
      for (int s = 0; s < N_STEPS; s++) step_q.push_back(3'(s));
      out_q.push_back(base);
      if (!rst_out) begin
        out_q.push_back(base + 32'd1);
        out_q.push_back(base + 32'd2);
      end
    end else step_q.push_back(STEP_CONV0);

    drive_load(nwords, opt);
    check("opt_q", 32'(opt_q), 32'(opt));

    if (calc_pulse) begin
      repeat (4) @(posedge clk);
      #1 in_valid = 1'b1;
      @(negedge clk);
      check("calc_in_ignored", 32'({img_we, ker_we, w_we}), 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end

    if (rst_out) begin
      for (k = 0; k < 3000; k++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      check("out_start_timeout", 32'(k < 3000), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_out_clear", {out_valid, step_valid, out[29:0]}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
    end

    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (out_q.size() == 0 && step_q.size() == 0) break;
    end
    check("drain_queues", 32'(out_q.size() + step_q.size()), 32'd0);
    check("step0_latency", 32'(step0_cyc - load_start), 32'd26);
    repeat (lat + 8) @(posedge clk);
    #1 check("back_idle", 32'({step_valid, out_valid, img_we}), 32'd0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opt_in   = 1'b0;
    res      = '0;
    #23 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({img_we, img_addr, ker_we, ker_addr, w_we, w_addr,
                                  opt_q, step_valid, step_id, out_valid}), 32'd0);
    end

    run_pattern(1'b1, 3,  IMG_WORDS, 1'b0, 1'b0, 32'h3F80_0000);
    run_pattern(1'b0, 40, IMG_WORDS, 1'b0, 1'b0, 32'h4100_0010);
    run_pattern(1'b0, 3,  30,        1'b0, 1'b0, 32'h0000_0000);
    run_pattern(1'b1, 3,  IMG_WORDS, 1'b0, 1'b0, 32'hC020_0000);
    run_pattern(1'b1, 3,  IMG_WORDS, 1'b0, 1'b1, 32'h1234_5678);
    run_pattern(1'b0, 3,  IMG_WORDS, 1'b0, 1'b0, 32'hA5A5_0001);

    @(posedge clk);
    #1 step_done = 1'b1;
    @(posedge clk);
    #1 step_done = 1'b0;
    repeat (4) @(negedge clk);
    check("spurious_done_idle", 32'({step_valid, out_valid, img_we}), 32'd0);

    run_pattern(1'b1, 3, IMG_WORDS, 1'b1, 1'b0, 32'h7F7F_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
